// File: rtl/ascon_ctrl_pkg.sv
// ascon_pack: shared types and constants for the Ascon AEAD controller.
// State enum, post-permutation XOR selects and the last round index.
package ascon_pack;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    INIT,
    AD_WAIT,
    AD_PERM,
    PT_WAIT,
    PT_PERM,
    FINAL,
    DONE
  } state_e;

  localparam logic [1:0] XOR_NONE = 2'd0;
  localparam logic [1:0] XOR_DS   = 2'd1;
  localparam logic [1:0] XOR_KEY  = 2'd2;

  localparam logic [3:0] ROUND_MAX = 4'd11;

  // First round-constant index of a p^n permutation
  function automatic logic [3:0] round_start(input int unsigned n);
    return 4'(12 - n);
  endfunction

endpackage

// File: rtl/ascon_ctrl_round_counter.sv
// round_counter: round-constant index for the Ascon permutation.
// Loadable start value, saturating increment, flag at ROUND_MAX.
module round_counter
  import ascon_pack::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  output logic [3:0] cnt_o,
  output logic       last_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == ROUND_MAX);

  // Next count: clear beats load beats increment; holds at ROUND_MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && !last_o) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ascon_ctrl.sv
// ascon_ctrl: control FSM for an Ascon-128 encryption datapath.
// Optional abort input enabled by defining ASCON_CTRL_ABORT_EN.
module ascon_ctrl
  import ascon_pack::*;
#(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       last_block_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       data_ready_o,
  output logic       init_sel_o,
  output logic       en_reg_o,
  output logic [3:0] round_o,
  output logic       xor_data_en_o,
  output logic       xor_key_en_o,
  output logic [1:0] xor_down_sel_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  localparam logic [3:0] START_A = round_start(ROUNDS_A);
  localparam logic [3:0] START_B = round_start(ROUNDS_B);

  state_e     state_q;
  state_e     state_d;
  logic       last_q;
  logic       cv_q;

  logic       abort;
  logic       in_round;
  logic       wait_st;
  logic       accept;

  logic       cnt_clr;
  logic       cnt_load;
  logic [3:0] cnt_val;
  logic       cnt_inc;
  logic [3:0] cnt;
  logic       cnt_last;

`ifdef ASCON_CTRL_ABORT_EN
  assign abort = abort_i && (state_q != IDLE);
`else
  assign abort = 1'b0;
`endif

  assign in_round = (state_q == INIT)    ||
                    (state_q == AD_PERM) ||
                    (state_q == PT_PERM) ||
                    (state_q == FINAL);

  assign wait_st = (state_q == AD_WAIT) ||
                   (state_q == PT_WAIT);

  assign accept = wait_st && !abort && data_valid_i;

  round_counter u_round_counter (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .inc_i      (cnt_inc),
    .cnt_o      (cnt),
    .last_o     (cnt_last)
  );

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) state_d = LOAD;
        end
        LOAD: begin
          state_d = INIT;
        end
        INIT: begin
          if (cnt_last) state_d = AD_WAIT;
        end
        AD_WAIT: begin
          if (accept) state_d = AD_PERM;
        end
        AD_PERM: begin
          if (cnt_last) begin
            state_d = last_q ? PT_WAIT : AD_WAIT;
          end
        end
        PT_WAIT: begin
          if (accept) begin
            state_d = last_block_i ? FINAL : PT_PERM;
          end
        end
        PT_PERM: begin
          if (cnt_last) state_d = PT_WAIT;
        end
        FINAL: begin
          if (cnt_last) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath controls and round counter steering
  always_comb begin
    data_ready_o   = wait_st && !abort;
    init_sel_o     = (state_q == LOAD);
    en_reg_o       = (state_q == LOAD) || in_round || accept;
    round_o        = in_round ? cnt : 4'd0;
    xor_data_en_o  = accept;
    xor_key_en_o   = accept && (state_q == PT_WAIT) && last_block_i;
    xor_down_sel_o = XOR_NONE;
    cipher_valid_o = cv_q;
    tag_valid_o    = (state_q == DONE);
    busy_o         = (state_q != IDLE);
    cnt_clr        = abort;
    cnt_load       = 1'b0;
    cnt_val        = START_B;
    cnt_inc        = in_round;

    if (cnt_last) begin
      if ((state_q == INIT) || (state_q == FINAL)) begin
        xor_down_sel_o = XOR_KEY;
      end else if ((state_q == AD_PERM) && last_q) begin
        xor_down_sel_o = XOR_DS;
      end
    end

    if (state_q == LOAD) begin
      cnt_load = 1'b1;
      cnt_val  = START_A;
    end else if (accept) begin
      cnt_load = 1'b1;
      if ((state_q == PT_WAIT) && last_block_i) begin
        cnt_val = START_A;
      end
    end
  end

  // Last-block flag captured on every accepted block
  always_ff @(posedge clock_i) begin
    if (reset_i || abort) begin
      last_q <= 1'b0;
    end else if (accept) begin
      last_q <= last_block_i;
    end else if (state_q == DONE) begin
      last_q <= 1'b0;
    end
  end

  // Ciphertext valid one cycle after each plaintext accept
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cv_q <= 1'b0;
    end else begin
      cv_q <= accept && (state_q == PT_WAIT);
    end
  end

endmodule

// File: tb/tb_ascon_ctrl.sv
// tb_ascon_ctrl: schedule-based self-checking bench for ascon_ctrl.
// Abort scenario compiled in when ASCON_CTRL_ABORT_EN is defined.
module tb_ascon_ctrl;

  localparam int RA = 12;
  localparam int RB = 6;

  typedef struct packed {
    logic rst;
    logic start;
    logic valid;
    logic last;
    logic abort;
  } stim_t;

  typedef struct packed {
    logic       rdy;
    logic       isel;
    logic       en;
    logic [3:0] rnd;
    logic       xd;
    logic       xk;
    logic [1:0] xdn;
    logic       cv;
    logic       tv;
    logic       busy;
  } out_t;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       data_valid_i;
  logic       last_block_i;
`ifdef ASCON_CTRL_ABORT_EN
  logic       abort_i;
`endif
  logic       data_ready_o;
  logic       init_sel_o;
  logic       en_reg_o;
  logic [3:0] round_o;
  logic       xor_data_en_o;
  logic       xor_key_en_o;
  logic [1:0] xor_down_sel_o;
  logic       cipher_valid_o;
  logic       tag_valid_o;
  logic       busy_o;

  out_t obs;

  stim_t sq[$];
  out_t  eq[$];
  stim_t ts[$];
  out_t  te[$];

  int total = 0;
  int bad   = 0;
  int cvcnt = 0;
  int cyc   = 0;

  always #5 clock_i = ~clock_i;

  ascon_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .data_valid_i   (data_valid_i),
    .last_block_i   (last_block_i),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i        (abort_i),
`endif
    .data_ready_o   (data_ready_o),
    .init_sel_o     (init_sel_o),
    .en_reg_o       (en_reg_o),
    .round_o        (round_o),
    .xor_data_en_o  (xor_data_en_o),
    .xor_key_en_o   (xor_key_en_o),
    .xor_down_sel_o (xor_down_sel_o),
    .cipher_valid_o (cipher_valid_o),
    .tag_valid_o    (tag_valid_o),
    .busy_o         (busy_o)
  );

  assign obs = {data_ready_o, init_sel_o, en_reg_o, round_o,
                xor_data_en_o, xor_key_en_o, xor_down_sel_o,
                cipher_valid_o, tag_valid_o, busy_o};

  // Inputs the controller must ignore in the current cycle
  function automatic stim_t rs(input bit hold);
    stim_t s;
    s = '0;
    s.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
    s.valid = 1'($urandom_range(0, 1));
    s.last  = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic put(input stim_t s, input out_t e);
    ts.push_back(s);
    te.push_back(e);
  endtask

  task automatic idle(input int n);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s = '0;
      s.valid = 1'($urandom_range(0, 1));
      s.last  = 1'($urandom_range(0, 1));
      sq.push_back(s);
      eq.push_back(out_t'(0));
    end
  endtask

  // A p^n permutation: n cycles, indices 12-n .. 11
  task automatic rounds(input int n, input logic [1:0] dn,
                        input bit hold, input bit cvf);
    stim_t s;
    out_t  e;
    for (int r = 12 - n; r <= 11; r++) begin
      s = rs(hold);
      e = '0;
      e.en   = 1'b1;
      e.busy = 1'b1;
      e.rnd  = 4'(r);
      e.xdn  = (r == 11) ? dn : 2'd0;
      e.cv   = cvf && (r == 12 - n);
      put(s, e);
    end
  endtask

  // g idle wait cycles then one accepted block
  task automatic blk(input bit last, input int g,
                     input bit hold, input bit pt);
    stim_t s;
    out_t  e;
    for (int k = 0; k < g; k++) begin
      s = rs(hold);
      s.valid = 1'b0;
      e = '0;
      e.rdy  = 1'b1;
      e.busy = 1'b1;
      put(s, e);
    end
    s = rs(hold);
    s.valid = 1'b1;
    s.last  = last;
    e = '0;
    e.rdy  = 1'b1;
    e.xd   = 1'b1;
    e.en   = 1'b1;
    e.busy = 1'b1;
    e.xk   = pt && last;
    put(s, e);
  endtask

  // One encryption; mg>=0 random gaps up to mg, mg<0 fixed gap -mg.
  // cut>=0 stops the operation with reset (or abort) at that cycle.
  task automatic op(input int nad, input int npt, input int mg,
                    input bit hold, input int cut, input bit ab);
    stim_t s;
    out_t  e;
    int    g;
    ts.delete();
    te.delete();
    s = rs(hold);
    s.start = 1'b1;
    put(s, out_t'(0));
    s = rs(hold);
    e = '0;
    e.isel = 1'b1;
    e.en   = 1'b1;
    e.busy = 1'b1;
    put(s, e);
    rounds(RA, 2'd2, hold, 1'b0);
    for (int i = 0; i < nad; i++) begin
      g = (mg >= 0) ? $urandom_range(0, mg) : -mg;
      blk(i == nad - 1, g, hold, 1'b0);
      rounds(RB, (i == nad - 1) ? 2'd1 : 2'd0, hold, 1'b0);
    end
    for (int j = 0; j < npt; j++) begin
      g = (mg >= 0) ? $urandom_range(0, mg) : -mg;
      blk(j == npt - 1, g, hold, 1'b1);
      if (j == npt - 1) rounds(RA, 2'd2, hold, 1'b1);
      else rounds(RB, 2'd0, hold, 1'b1);
    end
    s = rs(hold);
    e = '0;
    e.tv   = 1'b1;
    e.busy = 1'b1;
    put(s, e);
    if (cut >= 0 && cut < ts.size()) begin
      while (ts.size() > cut + 1) begin
        void'(ts.pop_back());
        void'(te.pop_back());
      end
      if (ab) ts[cut].abort = 1'b1;
      else ts[cut].rst = 1'b1;
    end
    foreach (ts[k]) begin
      sq.push_back(ts[k]);
      eq.push_back(te[k]);
    end
  endtask

  task automatic chk(input string tag, input int o, input int x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, x);
    end
  endtask

  // Drive each scheduled cycle after the edge, compare before the next
  task automatic run();
    stim_t s;
    out_t  e;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      e = eq.pop_front();
      reset_i      = s.rst;
      start_i      = s.start;
      data_valid_i = s.valid;
      last_block_i = s.last;
`ifdef ASCON_CTRL_ABORT_EN
      abort_i      = s.abort;
`endif
      @(negedge clock_i);
      if (cipher_valid_o === 1'b1) cvcnt++;
      chk("cycle", int'(obs), int'(e));
      @(posedge clock_i);
      #1;
      cyc++;
    end
  endtask

  initial begin
    reset_i      = 1'b1;
    start_i      = 1'b1;
    data_valid_i = 1'b1;
    last_block_i = 1'b1;
`ifdef ASCON_CTRL_ABORT_EN
    abort_i      = 1'b0;
`endif
    repeat (2) @(posedge clock_i);
    #1;
    start_i = 1'b0;
    @(negedge clock_i);
    chk("reset_state", int'(obs), 0);
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;

    // Nominal single-block flow, exact cycle schedule
    op(1, 1, 0, 1'b0, -1, 1'b0);
    idle(2);
    run();

    // Reset while INIT shows round 5
    op(1, 1, 0, 1'b0, 7, 1'b0);
    idle(2);
    run();

    // Three plaintext blocks with 4-cycle valid gaps
    cvcnt = 0;
    op(1, 3, -4, 1'b0, -1, 1'b0);
    idle(1);
    run();
    chk("cv_pulses", cvcnt, 3);

    // start_i held high: back-to-back operations only via IDLE
    cvcnt = 0;
    op(2, 2, 1, 1'b1, -1, 1'b0);
    op(1, 1, 1, 1'b1, -1, 1'b0);
    idle(2);
    run();
    chk("cv_pulses_hold", cvcnt, 3);

    // Randomized operations, some interrupted by reset
    for (int n = 0; n < 20; n++) begin
      op($urandom_range(1, 3), $urandom_range(1, 3), 3,
         1'($urandom_range(0, 3) == 0),
         ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : -1,
         1'b0);
      idle($urandom_range(0, 2));
      run();
    end

`ifdef ASCON_CTRL_ABORT_EN
    // Abort in PT_PERM round 8, then a normal run
    op(1, 2, 0, 1'b0, 24, 1'b1);
    idle(1);
    op(1, 1, 0, 1'b0, -1, 1'b0);
    idle(1);
    run();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
